// File: rtl/reg_write_arbiter.sv
// Arbitrates the register bank write port between host (A, priority) and demo engine (B),
// and schedules load_new commits at vertical blanking. Optional: REG_ARB_IMMEDIATE_EN.
module reg_write_arbiter #(
    parameter int CMD_BITS     = 4,
    parameter int DATA_BITS    = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vblank_start,
`ifdef REG_ARB_IMMEDIATE_EN
    input  logic                 immediate,
`endif
    input  logic                 a_req,
    input  logic [CMD_BITS-1:0]  a_cmd,
    input  logic [DATA_BITS-1:0] a_data,
    output logic                 a_ack,
    input  logic                 b_req,
    input  logic [CMD_BITS-1:0]  b_cmd,
    input  logic [DATA_BITS-1:0] b_data,
    output logic                 b_ack,
    input  logic                 batch,
    output logic                 wr_en,
    output logic [CMD_BITS-1:0]  wr_cmd,
    output logic [DATA_BITS-1:0] wr_data,
    output logic                 load_new,
    output logic                 busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, WRITE, COMMIT} state_t;

    state_t               state_q, state_d;
    logic                 pending_q, pending_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic [CMD_BITS-1:0]  wr_cmd_q, wr_cmd_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic                 a_ack_q, a_ack_d;
    logic                 b_ack_q, b_ack_d;
    logic                 wr_en_q, load_new_q, busy_q;
    logic                 commit_req;
    logic                 b_starved;

    assign b_starved = b_req && (starve_q == SW'(STARVE_LIMIT));

`ifdef REG_ARB_IMMEDIATE_EN
    assign commit_req = vblank_start || ((state_q == WRITE) && immediate);
`else
    assign commit_req = vblank_start;
`endif

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        wr_cmd_d  = wr_cmd_q;
        wr_data_d = wr_data_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending commit outranks any new grant so it lands in this blanking interval.
                if (pending_q && !batch) begin
                    state_d = COMMIT;
                end else if (a_req && !b_starved) begin
                    state_d   = WRITE;
                    a_ack_d   = 1'b1;
                    wr_cmd_d  = a_cmd;
                    wr_data_d = a_data;
                    starve_d  = b_req ? starve_q + 1'b1 : '0;
                end else if (b_req) begin
                    state_d   = WRITE;
                    b_ack_d   = 1'b1;
                    wr_cmd_d  = b_cmd;
                    wr_data_d = b_data;
                    starve_d  = '0;
                end else begin
                    starve_d = '0;
                end
            end
            WRITE:   state_d = IDLE;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A vblank landing on the commit cycle itself re-arms for a second commit.
        pending_d = commit_req || (pending_q && (state_q != COMMIT));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            starve_q   <= '0;
            wr_cmd_q   <= '0;
            wr_data_q  <= '0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            load_new_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            starve_q   <= starve_d;
            wr_cmd_q   <= wr_cmd_d;
            wr_data_q  <= wr_data_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            wr_en_q    <= (state_d == WRITE);
            load_new_q <= (state_d == COMMIT);
            busy_q     <= (state_d != IDLE) || pending_d;
        end
    end

    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign wr_en    = wr_en_q;
    assign wr_cmd   = wr_cmd_q;
    assign wr_data  = wr_data_q;
    assign load_new = load_new_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter; status vector is {wr_en, a_ack, b_ack, load_new, busy}.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vblank_start;
`ifdef REG_ARB_IMMEDIATE_EN
    logic        immediate;
`endif
    logic        a_req, b_req, batch;
    logic [3:0]  a_cmd, b_cmd;
    logic [15:0] a_data, b_data;
    logic        a_ack, b_ack, wr_en, load_new, busy;
    logic [3:0]  wr_cmd;
    logic [15:0] wr_data;
    logic [4:0]  st;

    int errs = 0;
    int checks = 0;
    int ln_cnt = 0;
    int wn_cnt = 0;

    always #5 clk = ~clk;

    assign st = {wr_en, a_ack, b_ack, load_new, busy};

    always @(negedge clk) begin
        if (load_new === 1'b1) ln_cnt++;
        if (wr_en === 1'b1) wn_cnt++;
    end

    reg_write_arbiter #(.CMD_BITS(4), .DATA_BITS(16), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .vblank_start(vblank_start),
`ifdef REG_ARB_IMMEDIATE_EN
        .immediate(immediate),
`endif
        .a_req(a_req), .a_cmd(a_cmd), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_cmd(b_cmd), .b_data(b_data), .b_ack(b_ack),
        .batch(batch), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_data(wr_data),
        .load_new(load_new), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; vblank_start = 1'b1; a_req = 1'b1; b_req = 1'b1; batch = 1'b0;
        a_cmd = 4'hF; a_data = 16'hFFFF; b_cmd = 4'hE; b_data = 16'hEEEE;
`ifdef REG_ARB_IMMEDIATE_EN
        immediate = 1'b0;
`endif
        tick(); tick();
        checks++; if (st !== 5'b00000) begin errs++; $display("FAIL reset_status: got %b want 00000", st); end
        checks++; if ({wr_cmd, wr_data} !== 20'h0) begin errs++; $display("FAIL reset_bus: got %h/%h want 0/0", wr_cmd, wr_data); end
        vblank_start = 1'b0; a_req = 1'b0; b_req = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        a_req = 1'b1; a_cmd = 4'h3; a_data = 16'h0A15;
        checks++; if (st !== 5'b00000) begin errs++; $display("FAIL single_pre: got %b want 00000", st); end
        tick();
        checks++; if (st !== 5'b11001) begin errs++; $display("FAIL single_write: got %b want 11001", st); end
        checks++; if (wr_cmd !== 4'h3 || wr_data !== 16'h0A15) begin errs++; $display("FAIL single_bus: got %h/%h want 3/0a15", wr_cmd, wr_data); end
        a_req = 1'b0; a_cmd = 4'h0; a_data = 16'h0;
        tick();
        checks++; if (st !== 5'b00000) begin errs++; $display("FAIL single_post: got %b want 00000", st); end
        checks++; if (wr_cmd !== 4'h3 || wr_data !== 16'h0A15) begin errs++; $display("FAIL single_hold: got %h/%h want 3/0a15", wr_cmd, wr_data); end
    endtask

    task automatic test_reset_abort();
        a_req = 1'b1; a_cmd = 4'h5; a_data = 16'h1234;
        #2 reset_n = 1'b0;
        tick();
        checks++; if (st !== 5'b00000 || wr_cmd !== 4'h0) begin errs++; $display("FAIL reset_abort: got %b/%h want 00000/0", st, wr_cmd); end
        a_req = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_vblank_commit();
        vblank_start = 1'b1;
        checks++; if (st !== 5'b00000) begin errs++; $display("FAIL vb_n: got %b want 00000", st); end
        tick(); vblank_start = 1'b0;
        checks++; if (st !== 5'b00001) begin errs++; $display("FAIL vb_n1: got %b want 00001", st); end
        tick();
        checks++; if (st !== 5'b00011) begin errs++; $display("FAIL vb_n2: got %b want 00011", st); end
        tick();
        checks++; if (st !== 5'b00000) begin errs++; $display("FAIL vb_n3: got %b want 00000", st); end
    endtask

    task automatic test_commit_deferred();
        a_req = 1'b1; a_cmd = 4'h7; a_data = 16'hBEEF; vblank_start = 1'b1;
        tick(); a_req = 1'b0; vblank_start = 1'b0;
        checks++; if (st !== 5'b11001) begin errs++; $display("FAIL defer_n1: got %b want 11001", st); end
        tick();
        checks++; if (st !== 5'b00001) begin errs++; $display("FAIL defer_n2: got %b want 00001", st); end
        tick();
        checks++; if (st !== 5'b00011) begin errs++; $display("FAIL defer_n3: got %b want 00011", st); end
        tick();
        checks++; if (st !== 5'b00000) begin errs++; $display("FAIL defer_n4: got %b want 00000", st); end
    endtask

    task automatic test_double_commit();
        vblank_start = 1'b1;
        tick(); vblank_start = 1'b0;
        tick();
        checks++; if (st !== 5'b00011) begin errs++; $display("FAIL dbl_first: got %b want 00011", st); end
        vblank_start = 1'b1;
        tick(); vblank_start = 1'b0;
        checks++; if (st !== 5'b00001) begin errs++; $display("FAIL dbl_pend: got %b want 00001", st); end
        tick();
        checks++; if (st !== 5'b00011) begin errs++; $display("FAIL dbl_second: got %b want 00011", st); end
        tick();
        checks++; if (st !== 5'b00000) begin errs++; $display("FAIL dbl_end: got %b want 00000", st); end
    endtask

    task automatic test_commit_priority();
        vblank_start = 1'b1;
        tick(); vblank_start = 1'b0;
        a_req = 1'b1; a_cmd = 4'h9; a_data = 16'h1111;
        tick();
        checks++; if (st !== 5'b00011) begin errs++; $display("FAIL prio_commit: got %b want 00011", st); end
        tick();
        checks++; if (st !== 5'b00000) begin errs++; $display("FAIL prio_idle: got %b want 00000", st); end
        tick(); a_req = 1'b0;
        checks++; if (st !== 5'b11001 || wr_data !== 16'h1111) begin errs++; $display("FAIL prio_write: got %b/%h want 11001/1111", st, wr_data); end
        tick();
    endtask

    task automatic test_batch();
        int ln0, wn0;
        ln0 = ln_cnt; wn0 = wn_cnt;
        batch = 1'b1;
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        a_req = 1'b1; a_cmd = 4'h1; a_data = 16'h00A1; tick(); a_req = 1'b0;
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        b_req = 1'b1; b_cmd = 4'h2; b_data = 16'h00B2; tick(); b_req = 1'b0;
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        repeat (4) tick();
        checks++; if (ln_cnt - ln0 != 0) begin errs++; $display("FAIL batch_no_commit: got %0d want 0", ln_cnt - ln0); end
        checks++; if (wn_cnt - wn0 != 2) begin errs++; $display("FAIL batch_writes: got %0d want 2", wn_cnt - wn0); end
        checks++; if (st !== 5'b00001) begin errs++; $display("FAIL batch_busy: got %b want 00001", st); end
        batch = 1'b0;
        tick();
        checks++; if (st !== 5'b00011) begin errs++; $display("FAIL batch_drop: got %b want 00011", st); end
        repeat (3) tick();
        checks++; if (ln_cnt - ln0 != 1 || st !== 5'b00000) begin errs++; $display("FAIL batch_single: got %0d/%b want 1/00000", ln_cnt - ln0, st); end
        // Batch released while a write is in flight
        batch = 1'b1;
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        a_req = 1'b1; a_cmd = 4'h6; a_data = 16'h6666; tick();
        checks++; if (st !== 5'b11001) begin errs++; $display("FAIL batch_wr: got %b want 11001", st); end
        batch = 1'b0; a_req = 1'b0;
        tick();
        checks++; if (st !== 5'b00001) begin errs++; $display("FAIL batch_wr_t1: got %b want 00001", st); end
        tick();
        checks++; if (st !== 5'b00011) begin errs++; $display("FAIL batch_wr_t2: got %b want 00011", st); end
        tick();
    endtask

    task automatic test_fairness();
        int gi;
        logic exp_b;
        gi = 0;
        a_req = 1'b1; a_cmd = 4'h1; a_data = 16'hAAAA;
        b_req = 1'b1; b_cmd = 4'h2; b_data = 16'hBBBB;
        for (int c = 0; c < 80 && gi < 27; c++) begin
            tick();
            if (wr_en === 1'b1) begin
                exp_b = (gi % 9 == 8);
                checks++;
                if (b_ack !== exp_b || a_ack !== !exp_b || wr_data !== (exp_b ? 16'hBBBB : 16'hAAAA)) begin
                    errs++;
                    $display("FAIL fair_grant%0d: got a=%b b=%b d=%h want b=%b", gi, a_ack, b_ack, wr_data, exp_b);
                end
                gi++;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        checks++; if (gi != 27) begin errs++; $display("FAIL fair_count: got %0d want 27", gi); end
        tick(); tick();
    endtask

    task automatic test_immediate();
        logic [4:0] e1, e2;
`ifdef REG_ARB_IMMEDIATE_EN
        e1 = 5'b00001; e2 = 5'b00011;
`else
        e1 = 5'b00000; e2 = 5'b00000;
`endif
        b_req = 1'b1; b_cmd = 4'h4; b_data = 16'hC0DE;
        tick(); b_req = 1'b0;
        checks++; if (st !== 5'b10101 || wr_data !== 16'hC0DE) begin errs++; $display("FAIL imm_write: got %b/%h want 10101/c0de", st, wr_data); end
`ifdef REG_ARB_IMMEDIATE_EN
        immediate = 1'b1;
`endif
        tick();
`ifdef REG_ARB_IMMEDIATE_EN
        immediate = 1'b0;
`endif
        checks++; if (st !== e1) begin errs++; $display("FAIL imm_n1: got %b want %b", st, e1); end
        tick();
        checks++; if (st !== e2) begin errs++; $display("FAIL imm_n2: got %b want %b", st, e2); end
        tick();
        checks++; if (st !== 5'b00000) begin errs++; $display("FAIL imm_end: got %b want 00000", st); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_reset_abort();
        test_vblank_commit();
        test_commit_deferred();
        test_double_commit();
        test_commit_priority();
        test_batch();
        test_fairness();
        test_immediate();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
